mul_result_uart_tx: RTL
=======================

Name: mul_result_uart_tx

Overview:
Downstream stage of the 8-bit multiplier. It captures the 16-bit product through a valid/ready handshake and serialises it on a UART TX line as two 8N1 frames: high byte first, then low byte. It isolates the combinational multiplier from the slow serial link and reports when the result has fully left the chip.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
HIGH_FIRST, 1, 1 = send prod[15:8] first, 0 = send prod[7:0] first.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
prod_valid  input  1  product on prod is valid
prod  input  16  product from multiplier
prod_ready  output  1  block can accept a product (high only in IDLE)
tx  output  1  UART serial out, idle high
busy  output  1  transaction in progress (not IDLE)
done  output  1  one-cycle pulse when second stop bit completes

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, tx=1, prod_ready=1, busy=0, done=0. Bit counter, baud counter and byte index are cleared. Shift register value is don't-care.
- Reset mid-frame aborts the transaction. tx=1 from the next edge; no partial completion; done stays 0.
- All outputs are registered. tx is driven from a flop.
- Handshake: accept when prod_valid && prod_ready at an edge (E0). prod is latched at E0; later changes to prod are ignored. prod_valid without prod_ready is ignored, not queued.
- States:
  - IDLE: tx=1, prod_ready=1.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
- Transitions:
  - IDLE→START on accept.
  - START→DATA when the baud counter reaches CLKS_PER_BIT-1.
  - DATA→STOP after bit 7 completes.
  - STOP→START (byte index 0→1, load second byte) with no idle gap.
  - STOP→IDLE after byte 1.
- Timing:
  - tx goes low from E0.
  - Each frame is 10*CLKS_PER_BIT cycles.
  - Return to IDLE at edge E0+20*CLKS_PER_BIT. In the cycle that follows, done=1 and prod_ready=1.
  - done deasserts at the next edge.
- Back-to-back: prod_valid held high is accepted at the first edge where prod_ready=1. The next start bit begins that same edge, so the line is idle for exactly one cycle between transactions.
- busy = (state != IDLE); prod_ready = ~busy.
- The baud counter is wide enough for CLKS_PER_BIT-1. It wraps to 0 at each bit boundary.

Test Plan:
- Reset check (CLKS_PER_BIT=4): hold rst_n=0 for 3 cycles, then release → tx=1, prod_ready=1, busy=0, done=0 throughout.
- Single product (CLKS_PER_BIT=4, HIGH_FIRST=1): prod=16'hA55A, valid for 1 cycle at E0.
  - Sample tx mid-bit → start 0, bits 1,0,1,0,0,1,0,1 (0xA5), stop 1; then start 0, bits 0,1,0,1,1,0,1,0 (0x5A), stop 1.
  - done pulses exactly once, in the cycle after edge E0+80.
- Input stability: change prod to 16'hFFFF and pulse prod_valid during the first frame → serial output is still 0xA5, 0x5A. The second valid is not accepted, and prod_ready=0 throughout.
- Byte order (HIGH_FIRST=0): prod=16'h1234 → frames 0x34 then 0x12.
- Back-to-back: hold prod_valid=1 with prod=16'h00FF then 16'hFF00 → two transactions with tx=1 for exactly one cycle between the second stop bit and the next start bit. Decoded bytes are 0x00, 0xFF, 0xFF, 0x00.
- Reset mid-operation: assert rst_n=0 during bit 3 of the first byte → tx=1 from the next edge, done never pulses. After release, a new prod=16'h0001 transmits cleanly (0x00, 0x01).

Source files
------------

// File: rtl/mul_result_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_result_uart_tx_if
// Description : Product handshake and UART status bundle between the
//               multiplier side and the serial transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_result_uart_tx_if;
    logic        prod_valid;
    logic [15:0] prod;
    logic        prod_ready;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (
        output prod_valid, prod,
        input  prod_ready, tx, busy, done
    );

    modport slave (
        input  prod_valid, prod,
        output prod_ready, tx, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/mul_result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mul_result_uart_tx
// Description : Captures a 16-bit product and sends it as two back-to-back
//               8N1 UART frames, pulsing done when the last stop bit ends.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_result_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter bit HIGH_FIRST   = 1'b1
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mul_result_uart_tx_if.slave bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] C_BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic            byte_q, byte_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      second_q, second_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic            w_baud_end;

    assign w_baud_end = (baud_q == C_BAUD_MAX);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shift_d  = shift_q;
        second_d = second_q;
        tx_d     = tx_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                // ready_q mirrors IDLE, so this is exactly the handshake edge
                if (bus.prod_valid && ready_q) begin
                    state_d  = S_START;
                    tx_d     = 1'b0;
                    baud_d   = '0;
                    byte_d   = 1'b0;
                    shift_d  = HIGH_FIRST ? bus.prod[15:8] : bus.prod[7:0];
                    second_d = HIGH_FIRST ? bus.prod[7:0]  : bus.prod[15:8];
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    baud_d = '0;
                    if (!byte_q) begin
                        // second frame follows immediately, no idle gap
                        byte_d  = 1'b1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                        shift_d = second_q;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            byte_q   <= 1'b0;
            shift_q  <= 8'd0;
            second_q <= 8'd0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shift_q  <= shift_d;
            second_q <= second_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.prod_ready = ready_q;

endmodule
`default_nettype wire
